// File: rtl/sized_fifo_umf_if.sv
// sized_fifo_umf_if: handshake bundle between a UMF chunk producer/consumer and the FIFO.
//   master: drives enq_1, EN_enq, EN_deq, EN_clear; observes data and readiness flags
//   slave : the FIFO side, driving first and all RDY_*/notFull/notEmpty outputs
interface sized_fifo_umf_if #(
    parameter int WIDTH = 128
);
    logic [WIDTH-1:0] enq_1;
    logic             EN_enq;
    logic             RDY_enq;
    logic             EN_deq;
    logic             RDY_deq;
    logic [WIDTH-1:0] first;
    logic             RDY_first;
    logic             notFull;
    logic             RDY_notFull;
    logic             notEmpty;
    logic             RDY_notEmpty;
    logic             EN_clear;
    logic             RDY_clear;

    modport master (
        output enq_1, EN_enq, EN_deq, EN_clear,
        input  RDY_enq, RDY_deq, first, RDY_first, notFull, RDY_notFull,
               notEmpty, RDY_notEmpty, RDY_clear
    );

    modport slave (
        input  enq_1, EN_enq, EN_deq, EN_clear,
        output RDY_enq, RDY_deq, first, RDY_first, notFull, RDY_notFull,
               notEmpty, RDY_notEmpty, RDY_clear
    );
endinterface

// File: rtl/sized_fifo_umf.sv
// sized_fifo_umf: single-clock FIFO of DEPTH x WIDTH UMF chunks with Bluespec-style handshakes.
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset (empties the FIFO)
//   bus   : slave side of sized_fifo_umf_if (enqueue, dequeue, clear, head data, flags)
module sized_fifo_umf #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input logic              CLK,
    input logic              RST_N,
    sized_fifo_umf_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wp, rp;
    logic [ADDR_WIDTH:0]   count;
    logic                  full, empty, do_enq, do_deq;

    // Flags come from the registered count only, so no EN_* input reaches an output.
    assign full   = count == FULL_CNT;
    assign empty  = count == '0;
    assign do_enq = bus.EN_enq && !full;
    assign do_deq = bus.EN_deq && !empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (bus.EN_clear) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_enq) wp <= wp + PTR_ONE;
            if (do_deq) rp <= rp + PTR_ONE;
            if (do_enq != do_deq) count <= do_enq ? count + CNT_ONE : count - CNT_ONE;
        end
    end

    // Storage is deliberately not reset; a clear discards the write along with the pointers.
    always_ff @(posedge CLK) begin
        if (do_enq && !bus.EN_clear) mem[wp] <= bus.enq_1;
    end

    assign bus.first        = mem[rp];
    assign bus.notFull      = !full;
    assign bus.RDY_enq      = !full;
    assign bus.notEmpty     = !empty;
    assign bus.RDY_deq      = !empty;
    assign bus.RDY_first    = !empty;
    assign bus.RDY_notFull  = 1'b1;
    assign bus.RDY_notEmpty = 1'b1;
    assign bus.RDY_clear    = 1'b1;
endmodule

// File: tb/tb_sized_fifo_umf.sv
// tb_sized_fifo_umf: randomized scoreboard bench for sized_fifo_umf against a queue model.
module tb_sized_fifo_umf;
    localparam int W = 128;
    localparam int D = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mcount = 0;
    bit   exp_deq = 1'b0;
    logic [W-1:0] exp_q[$];

    sized_fifo_umf_if #(.WIDTH(W)) bus ();
    sized_fifo_umf #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(6)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, " RDY_enq"}, W'(bus.RDY_enq), W'(mcount < D));
        chk({tag, " notFull"}, W'(bus.notFull), W'(mcount < D));
        chk({tag, " notEmpty"}, W'(bus.notEmpty), W'(mcount > 0));
        chk({tag, " RDY_deq"}, W'(bus.RDY_deq), W'(mcount > 0));
        chk({tag, " RDY_first"}, W'(bus.RDY_first), W'(mcount > 0));
        chk({tag, " RDY_const"}, W'({bus.RDY_notFull, bus.RDY_notEmpty, bus.RDY_clear}), W'(3'b111));
    endtask

    // One cycle: check flags left by the previous edge, drive strobes, advance the model.
    task automatic cyc(input bit en, input bit de, input bit cl, input logic [W-1:0] d, output bit enq_ok);
        bit ef, df;
        @(negedge clk);
        chk_flags("cyc");
        bus.enq_1 = d;
        bus.EN_enq = en;
        bus.EN_deq = de;
        bus.EN_clear = cl;
        ef = en && mcount < D && !cl;
        df = de && mcount > 0 && !cl;
        exp_deq = df;
        if (cl) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            if (ef) exp_q.push_back(d);
            mcount = mcount + int'(ef) - int'(df);
        end
        enq_ok = ef;
    endtask

    // Monitor: whenever the model says a dequeue is happening, the head must match.
    initial forever begin
        @(negedge clk);
        #2;
        if (exp_deq) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL underflow got dequeue expected none");
            end else chk("first", bus.first, exp_q.pop_front());
        end
    end

    initial begin
        bit ok;
        int v, n;
        bus.enq_1 = '0;
        bus.EN_enq = 1'b0;
        bus.EN_deq = 1'b0;
        bus.EN_clear = 1'b0;
        #1;
        chk_flags("reset");
        #11 rst_n = 1'b1;

        cyc(1, 0, 0, W'('hA5), ok);
        cyc(0, 0, 0, '0, ok);
        chk("single first", bus.first, W'('hA5));
        cyc(0, 1, 0, '0, ok);
        cyc(0, 0, 0, '0, ok);

        for (int i = 0; i < D; i++) cyc(1, 0, 0, W'(i), ok);
        cyc(1, 0, 0, W'('hFF), ok);
        cyc(1, 1, 0, W'('hEE), ok);
        cyc(0, 0, 0, '0, ok);
        for (int i = 0; i < D - 1; i++) cyc(0, 1, 0, '0, ok);
        cyc(0, 0, 0, '0, ok);

        for (int i = 0; i < 3; i++) cyc(1, 0, 0, W'(32'h300 + i), ok);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, W'(32'h400 + i), ok);
        cyc(0, 0, 0, '0, ok);
        chk("steady count", W'(mcount), W'(3));
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, ok);
        cyc(0, 0, 0, '0, ok);

        v = 0;
        n = 0;
        while ((v < 200 || mcount > 0) && n < 4000) begin
            cyc(v < 200 && ($urandom_range(0, 2) != 0), $urandom_range(0, 2) == 0, 0,
                {W'($urandom) << 32, W'(v)}, ok);
            if (ok) v++;
            n++;
        end
        chk("stream done", W'(v + mcount), W'(200));
        cyc(0, 0, 0, '0, ok);

        for (int i = 0; i < 5; i++) cyc(1, 0, 0, W'(32'h500 + i), ok);
        cyc(1, 0, 1, W'('h77), ok);
        cyc(1, 0, 0, W'('h88), ok);
        cyc(0, 1, 0, '0, ok);
        cyc(0, 0, 0, '0, ok);

        for (int i = 0; i < 10; i++) cyc(1, 0, 0, W'(32'h600 + i), ok);
        cyc(0, 0, 0, '0, ok);
        #3 rst_n = 1'b0;
        mcount = 0;
        exp_q.delete();
        #1;
        chk_flags("async reset");
        #2 rst_n = 1'b1;
        cyc(1, 0, 0, W'('h99), ok);
        cyc(0, 1, 0, '0, ok);
        cyc(0, 0, 0, '0, ok);
        chk("model drained", W'(exp_q.size()), W'(mcount));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
